// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: per-cycle action
// codes, the WDSel value that marks a load, and forwarding select codes.
package pipe_pkg;

   // Action taken by the hazard controller in the current cycle
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2,
      ST_WAIT  = 2'd3
   } state_t;

   // Operand source picked by the ID_EXE forwarding mux
   typedef enum logic [1:0] {
      FWD_NONE = 2'd0,
      FWD_EX   = 2'd1,
      FWD_MEM  = 2'd2,
      FWD_WB   = 2'd3
   } fwd_t;

   // WDSel code of an instruction whose writeback data comes from memory
   localparam logic [1:0] WDSEL_LOAD = 2'b01;

   // True when a producer destination feeds a live, non-x0 source register
   function automatic logic reg_hit(input logic [4:0] dst,
                                    input logic [4:0] src,
                                    input logic       use_src);
      return use_src && (src != 5'd0) && (dst == src);
   endfunction

endpackage

// File: rtl/fwd_sel_unit.sv
// Forwarding select for one ID source operand. The youngest producer wins:
// EX over MEM over WB, so the value seen is the most recent write.
module fwd_sel_unit
   import pipe_pkg::*;
(
   input  logic [4:0] rs,
   input  logic       use_rs,
   input  logic [4:0] ex_wregnum,
   input  logic [4:0] mem_wregnum,
   input  logic [4:0] wb_wregnum,
   input  logic       ex_RegWrite,
   input  logic       mem_RegWrite,
   input  logic       wb_RegWrite,
   output logic [1:0] fwd_sel
);

   // Priority match of the source against in-flight destinations
   always_comb begin
      fwd_sel = FWD_NONE;
      if (ex_RegWrite && reg_hit(ex_wregnum, rs, use_rs))
         fwd_sel = FWD_EX;
      else if (mem_RegWrite && reg_hit(mem_wregnum, rs, use_rs))
         fwd_sel = FWD_MEM;
      else if (wb_RegWrite && reg_hit(wb_wregnum, rs, use_rs))
         fwd_sel = FWD_WB;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: forwarding selects, load-use
// stall, branch flush, memory-busy hold with a deferred flush, a sticky
// watchdog on long memory stalls, and stall/flush performance counters.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int BUSY_LIMIT = 15
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic [4:0]  ex_wregnum,
   input  logic [4:0]  mem_wregnum,
   input  logic [4:0]  wb_wregnum,
   input  logic        ex_RegWrite,
   input  logic        mem_RegWrite,
   input  logic        wb_RegWrite,
   input  logic [1:0]  ex_WDSel,
   input  logic        ex_branch_taken,
   input  logic        mem_busy,
   output logic        pc_we,
   output logic        if_id_we,
   output logic        id_exe_we,
   output logic        exe_mem_we,
   output logic        mem_wb_we,
   output logic        if_id_clr,
   output logic        id_exe_clr,
   output logic [1:0]  rs1_fwd_sel,
   output logic [1:0]  rs2_fwd_sel,
   output logic [1:0]  state,
   output logic        busy_err,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   localparam int              BUSY_W   = $clog2(BUSY_LIMIT + 2);
   localparam logic [BUSY_W-1:0] BUSY_MAX = BUSY_W'(BUSY_LIMIT + 1);

   logic              flush_pend;
   logic              flush_pend_nxt;
   logic [BUSY_W-1:0] busy_cnt;
   logic [BUSY_W-1:0] busy_cnt_nxt;
   logic [1:0]        fwd1_raw;
   logic [1:0]        fwd2_raw;
   logic              load_use;
   state_t            act;

   fwd_sel_unit u_fwd_rs1 (
      .rs           (id_rs1),
      .use_rs       (id_use_rs1),
      .ex_wregnum   (ex_wregnum),
      .mem_wregnum  (mem_wregnum),
      .wb_wregnum   (wb_wregnum),
      .ex_RegWrite  (ex_RegWrite),
      .mem_RegWrite (mem_RegWrite),
      .wb_RegWrite  (wb_RegWrite),
      .fwd_sel      (fwd1_raw)
   );

   fwd_sel_unit u_fwd_rs2 (
      .rs           (id_rs2),
      .use_rs       (id_use_rs2),
      .ex_wregnum   (ex_wregnum),
      .mem_wregnum  (mem_wregnum),
      .wb_wregnum   (wb_wregnum),
      .ex_RegWrite  (ex_RegWrite),
      .mem_RegWrite (mem_RegWrite),
      .wb_RegWrite  (wb_RegWrite),
      .fwd_sel      (fwd2_raw)
   );

   // A load in EX cannot forward yet; its consumer in ID must wait a cycle
   always_comb begin
      load_use = ex_RegWrite && (ex_WDSel == WDSEL_LOAD) &&
                 (reg_hit(ex_wregnum, id_rs1, id_use_rs1) ||
                  reg_hit(ex_wregnum, id_rs2, id_use_rs2));
   end

   // Action select, enables, pending-flush and busy-counter next values
   always_comb begin
      act            = ST_RUN;
      pc_we          = 1'b1;
      if_id_we       = 1'b1;
      id_exe_we      = 1'b1;
      exe_mem_we     = 1'b1;
      mem_wb_we      = 1'b1;
      if_id_clr      = 1'b0;
      id_exe_clr     = 1'b0;
      flush_pend_nxt = flush_pend;
      busy_cnt_nxt   = '0;

      if (mem_busy) begin
         act        = ST_WAIT;
         pc_we      = 1'b0;
         if_id_we   = 1'b0;
         id_exe_we  = 1'b0;
         exe_mem_we = 1'b0;
         mem_wb_we  = 1'b0;
         // Remember a redirect seen while frozen so it is not lost
         if (ex_branch_taken)
            flush_pend_nxt = 1'b1;
         busy_cnt_nxt = (busy_cnt == BUSY_MAX) ? BUSY_MAX : busy_cnt + 1'b1;
      end else if (ex_branch_taken || flush_pend) begin
         act            = ST_FLUSH;
         if_id_clr      = 1'b1;
         id_exe_clr     = 1'b1;
         flush_pend_nxt = 1'b0;
      end else if (load_use) begin
         act        = ST_STALL;
         pc_we      = 1'b0;
         if_id_we   = 1'b0;
         id_exe_clr = 1'b1;
      end

      // Reset holds the pipeline frozen with bubbles at its front
      if (rst) begin
         pc_we      = 1'b0;
         if_id_we   = 1'b0;
         id_exe_we  = 1'b0;
         exe_mem_we = 1'b0;
         mem_wb_we  = 1'b0;
         if_id_clr  = 1'b1;
         id_exe_clr = 1'b1;
      end
   end

   assign state       = act;
   assign rs1_fwd_sel = rst ? FWD_NONE : fwd1_raw;
   assign rs2_fwd_sel = rst ? FWD_NONE : fwd2_raw;

   // Pending flush is the only control state; reset drops any deferred flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         flush_pend <= 1'b0;
      else
         flush_pend <= flush_pend_nxt;
   end

   // Memory-busy watchdog: saturating run length and sticky error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_cnt <= '0;
         busy_err <= 1'b0;
      end else begin
         busy_cnt <= busy_cnt_nxt;
         if (busy_cnt_nxt == BUSY_MAX)
            busy_err <= 1'b1;
      end
   end

   // Performance counters, free-running and wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (act == ST_STALL)
            stall_cnt <= stall_cnt + 32'd1;
         if (act == ST_FLUSH)
            flush_cnt <= flush_cnt + 32'd1;
      end
   end

endmodule
